// File: rtl/wb_stage.sv
// wb_stage: writeback stage merging load results and a FIFO of ALU results onto the register file write port
module wb_stage #(
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          alu_valid_i,
  input  logic [4:0]    alu_rd_i,
  input  logic [31:0]   alu_data_i,
  output logic          alu_ready_o,
  input  logic          mem_valid_i,
  input  logic [4:0]    mem_rd_i,
  input  logic [31:0]   mem_data_i,
  output logic [5:0]    writenum_o,
  output logic [31:0]   writedata_o,
  output logic [31:0]   pending_o,
  output logic [CW-1:0] fifo_count_o
);
  logic [4:0]    rd_q [FIFO_DEPTH];
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    writenum_q, writenum_d;
  logic [31:0]   writedata_q, writedata_d;
  logic          push, pop, nonempty;

  assign alu_ready_o  = count_q != CW'(FIFO_DEPTH);
  assign nonempty     = count_q != '0;
  assign push         = alu_valid_i && alu_ready_o;
  assign pop          = !mem_valid_i && nonempty;
  assign writenum_o   = writenum_q;
  assign writedata_o  = writedata_q;
  assign fifo_count_o = count_q;

  // Next state: loads win the write port; pop only sees entries present before this edge
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    writenum_d  = mem_valid_i ? {1'b1, mem_rd_i} : nonempty ? {1'b1, rd_q[rd_ptr_q]} : 6'b0;
    writedata_d = mem_valid_i ? mem_data_i : nonempty ? data_q[rd_ptr_q] : writedata_q;
  end

  // Pending mask: one bit per destination of every entry still queued
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (CW'(i) < count_q) pending_o[rd_q[rd_ptr_q + PW'(i)]] = 1'b1;
  end

  // Control and output registers; reset drops every queued result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      writenum_q  <= '0;
      writedata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      writenum_q  <= writenum_d;
      writedata_q <= writedata_d;
    end
  end

  // Entry storage, written at the tail on accept; contents are don't-care until occupied
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= alu_rd_i;
      data_q[wr_ptr_q] <= alu_data_i;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage against a queue-based behavioural model
module tb_wb_stage;
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  typedef struct { logic [5:0] wn; logic [31:0] wd; } wr_t;

  logic        clk = 1'b0, rst_i = 1'b1;
  logic        alu_valid_i = 1'b0, mem_valid_i = 1'b0;
  logic [4:0]  alu_rd_i = '0, mem_rd_i = '0;
  logic [31:0] alu_data_i = '0, mem_data_i = '0;
  logic        alu_ready_o;
  logic [5:0]  writenum_o;
  logic [31:0] writedata_o, pending_o;
  logic [2:0]  fifo_count_o;

  int checks = 0, errors = 0;
  ent_t mq[$];
  wr_t  sb[$];
  logic [31:0] last_wd = '0;

  wb_stage #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
    .writenum_o(writenum_o), .writedata_o(writedata_o), .pending_o(pending_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] pm = '0;
    foreach (mq[i]) pm[mq[i].rd] = 1'b1;
    chk({tag, ".count"}, 32'(fifo_count_o), mq.size());
    chk({tag, ".ready"}, 32'(alu_ready_o), 32'(mq.size() != 4));
    chk({tag, ".pending"}, pending_o, pm);
  endtask

  task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic av, input logic [4:0] ard, input logic [31:0] ad);
    wr_t w;
    ent_t e;
    logic acc;
    mem_valid_i = mv; mem_rd_i = mrd; mem_data_i = md;
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    @(posedge clk);
    acc = av && mq.size() != 4;
    if (mv) begin
      w.wn = {1'b1, mrd}; w.wd = md;
    end else if (mq.size() != 0) begin
      e = mq.pop_front(); w.wn = {1'b1, e.rd}; w.wd = e.d;
    end else begin
      w.wn = 6'b0; w.wd = last_wd;
    end
    last_wd = w.wd;
    if (acc) mq.push_back('{ard, ad});
    sb.push_back(w);
    #1;
    w = sb.pop_front();
    chk("writenum", 32'(writenum_o), 32'(w.wn));
    chk("writedata", writedata_o, w.wd);
    check_state("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int run = 0;
    logic mv;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.writenum", 32'(writenum_o), 0);
    chk("rst.writedata", writedata_o, 0);
    check_state("rst");
    @(negedge clk) rst_i = 1'b0;
    // single push rd5
    step(0, 0, 0, 1, 5, 32'h1234);
    chk("single.pend5", 32'(pending_o[5]), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("single.wn", 32'(writenum_o), 32'b100101);
    idle(2);
    // fill under loads, then drain in order; twice to exercise wrap
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 4; i++) step(1, 5'(9 + i), 32'hB0 + i, 1, 5'(i), 32'hA0 + i);
      chk("fill.ready", 32'(alu_ready_o), 0);
      idle(5);
    end
    // loads hold off a queued result
    step(1, 9, 32'h99, 1, 7, 32'h77);
    step(1, 9, 32'h99, 0, 0, 0);
    chk("load.count", 32'(fifo_count_o), 1);
    step(1, 9, 32'h99, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("load.rd7", 32'(writenum_o), 32'b100111);
    idle(1);
    // full FIFO with alu_valid held
    for (int i = 0; i < 4; i++) step(1, 20, 32'hC0 + i, 1, 5'(i + 12), 32'hD0 + i);
    step(1, 20, 32'hC9, 1, 30, 32'hE0);
    step(0, 0, 0, 1, 30, 32'hE0);
    step(0, 0, 0, 1, 31, 32'hE1);
    idle(6);
    // back-to-back writes to rd3
    step(0, 0, 0, 1, 3, 32'h10);
    step(0, 0, 0, 1, 3, 32'h20);
    step(0, 0, 0, 0, 0, 0);
    chk("b2b.wd", writedata_o, 32'h20);
    idle(2);
    // async reset with 3 entries queued
    for (int i = 0; i < 3; i++) step(1, 8, 32'hF0 + i, 1, 5'(i + 1), 32'h50 + i);
    #2 rst_i = 1'b1;
    #1;
    mq.delete(); sb.delete(); last_wd = '0;
    chk("arst.writenum", 32'(writenum_o), 0);
    chk("arst.writedata", writedata_o, 0);
    check_state("arst");
    @(negedge clk) rst_i = 1'b0;
    idle(3);
    // randomized traffic with bounded load bursts
    for (int i = 0; i < 400; i++) begin
      mv = (run < 8) && ($urandom_range(0, 2) == 0);
      run = mv ? run + 1 : 0;
      step(mv, 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
    end
    idle(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
